// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit pipelined CPU control slice.
//   hcu_state_t : sequencer states (RUN, MULDIV_WAIT, HALTED)
//   REG_ADDR_W  : register-specifier width (register 0 is hard-wired zero)
//   PC_INCR     : sequential program-counter increment (one 16-bit word)
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_ADDR_W = 4;

    localparam logic [15:0] PC_INCR = 16'h0002;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MULDIV_WAIT = 2'd1,
        HALTED      = 2'd2
    } hcu_state_t;

endpackage : cpu_pkg

// File: rtl/hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in EX
// is a load whose destination is read by the instruction in ID. Writes to
// register 0 never create a dependency because that register is constant.
// Ports:
//   id_rs, id_rt  : source registers of the ID instruction
//   id_uses_rt    : ID instruction actually reads rt
//   ex_mem_read   : EX instruction is a load
//   ex_rd         : destination register of the EX instruction
//   load_use      : dependency detected, ID must wait one cycle
// ----------------------------------------------------------------------------
module hazard_detect #(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    logic rd_nonzero_s;
    logic rs_match_s;
    logic rt_match_s;

    // Compare the load destination against each source the ID instruction reads.
    always_comb begin
        rd_nonzero_s = (ex_rd != {REG_ADDR_W{1'b0}});
        rs_match_s   = (ex_rd == id_rs);
        rt_match_s   = id_uses_rt && (ex_rd == id_rt);
        load_use     = ex_mem_read && rd_nonzero_s && (rs_match_s || rt_match_s);
    end

endmodule : hazard_detect

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
// Central pipeline sequencer. Generates PC / stage-buffer controls for
// load-use bubbles, taken branches, multi-cycle mul/div occupancy of EX and
// HALT, and keeps a saturating stall counter plus a sticky mul/div timeout.
// Control outputs are combinational from the current state and the inputs.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt/id_halt : ID-stage instruction information
//   ex_mem_read/ex_rd     : EX-stage load information
//   ex_branch_taken       : EX resolved a taken branch or jump
//   ex_muldiv_start       : EX began a multi-cycle mul/div (pulse)
//   muldiv_done           : mul/div result valid this cycle
//   pc_write/pc_src       : PC load enable / target select (1 = branch)
//   ifid_write/ifid_flush : IF/ID buffer enable / clear
//   idex_write/idex_flush : ID/EX buffer enable / clear (bubble)
//   exmem_flush           : EX/MEM buffer clear
//   halted                : core halted
//   muldiv_timeout        : sticky mul/div timeout error
//   stall_count           : saturating count of cycles with pc_write low
// ----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int REG_ADDR_W     = cpu_pkg::REG_ADDR_W,
    parameter int MULDIV_TIMEOUT = 32,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   ex_muldiv_start,
    input  logic                   muldiv_done,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_write,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   halted,
    output logic                   muldiv_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    import cpu_pkg::*;

    localparam int TO_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]        TO_LAST = TO_W'(MULDIV_TIMEOUT - 1);
    localparam logic [STALL_CNT_W-1:0] SC_MAX  = {STALL_CNT_W{1'b1}};

    hcu_state_t             state_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   timeout_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic load_use_s;
    logic pc_write_s;
    logic pc_src_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_write_s;
    logic idex_flush_s;
    logic exmem_flush_s;
    logic halted_s;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use_s)
    );

    // Pipeline control decode from current state and hazard inputs.
    always_comb begin
        pc_write_s    = 1'b1;
        pc_src_s      = 1'b0;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_write_s  = 1'b1;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        halted_s      = 1'b0;
        if (reset) begin
            // Freeze fetch and clear every stage buffer while in reset.
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_write_s  = 1'b0;
            idex_flush_s  = 1'b1;
            exmem_flush_s = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Redirect fetch and squash the two wrong-path instructions.
                        pc_src_s     = 1'b1;
                        ifid_flush_s = 1'b1;
                        idex_flush_s = 1'b1;
                    end else if (ex_muldiv_start) begin
                        // Start outranks load-use; EX is held from next cycle on.
                        pc_write_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                        idex_flush_s = 1'b1;
                    end else begin
                        pc_write_s = 1'b1;
                    end
                end
                MULDIV_WAIT: begin
                    if (muldiv_done) begin
                        // Released this cycle: behave as RUN, branches ignored.
                        if (load_use_s) begin
                            pc_write_s   = 1'b0;
                            ifid_write_s = 1'b0;
                            idex_flush_s = 1'b1;
                        end else begin
                            pc_write_s = 1'b1;
                        end
                    end else begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_write_s  = 1'b0;
                        exmem_flush_s = 1'b1;
                    end
                end
                HALTED: begin
                    pc_write_s   = 1'b0;
                    ifid_write_s = 1'b0;
                    idex_flush_s = 1'b1;
                    halted_s     = 1'b1;
                end
                default: begin
                    // Unreachable encoding: hold the pipeline frozen and clean.
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_write_s  = 1'b0;
                    ifid_flush_s  = 1'b1;
                    idex_flush_s  = 1'b1;
                    exmem_flush_s = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state, mul/div timeout tracking and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            to_cnt_r    <= {TO_W{1'b0}};
            timeout_r   <= 1'b0;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            if (!pc_write_s && (stall_cnt_r != SC_MAX)) begin
                stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end

            case (state_r)
                RUN: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    if (ex_branch_taken) begin
                        state_r <= RUN;
                    end else if (ex_muldiv_start) begin
                        state_r <= MULDIV_WAIT;
                    end else if (load_use_s) begin
                        state_r <= RUN;
                    end else if (id_halt) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MULDIV_WAIT: begin
                    if (muldiv_done) begin
                        state_r  <= RUN;
                        to_cnt_r <= {TO_W{1'b0}};
                    end else if (to_cnt_r == TO_LAST) begin
                        // Unit never answered: abandon the wait and flag it.
                        state_r   <= RUN;
                        to_cnt_r  <= {TO_W{1'b0}};
                        timeout_r <= 1'b1;
                    end else begin
                        state_r  <= MULDIV_WAIT;
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                HALTED: begin
                    state_r  <= HALTED;
                    to_cnt_r <= {TO_W{1'b0}};
                end
                default: begin
                    state_r  <= RUN;
                    to_cnt_r <= {TO_W{1'b0}};
                end
            endcase
        end
    end

    assign pc_write       = pc_write_s;
    assign pc_src         = pc_src_s;
    assign ifid_write     = ifid_write_s;
    assign ifid_flush     = ifid_flush_s;
    assign idex_write     = idex_write_s;
    assign idex_flush     = idex_flush_s;
    assign exmem_flush    = exmem_flush_s;
    assign halted         = halted_s;
    assign muldiv_timeout = timeout_r;
    assign stall_count    = stall_cnt_r;

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_control_unit
// Directed-vector bench. Each stimulus cycle pushes its hand-written expected
// control pattern and stall count into a queue; a monitor on the falling edge
// pops and compares against the DUT. The stall counter is 4 bits wide here so
// saturation is reached quickly.
// Control pattern bit order:
//   {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush,
//    exmem_flush, halted, muldiv_timeout}
// ----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int RW  = 4;
    localparam int SCW = 4;

    localparam logic [8:0] RUN_OK = 9'b1_0_1_0_1_0_0_0_0;
    localparam logic [8:0] LU     = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] BR     = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] WT     = 9'b0_0_0_0_0_0_1_0_0;
    localparam logic [8:0] HLT    = 9'b0_0_0_0_1_1_0_1_0;
    localparam logic [8:0] RST    = 9'b0_0_0_1_0_1_1_0_0;

    typedef struct {
        string          name;
        logic [8:0]     ctl;
        logic           chk_sc;
        logic [SCW-1:0] sc;
    } exp_t;

    logic           clk;
    logic           reset;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic           id_uses_rt;
    logic           id_halt;
    logic           ex_mem_read;
    logic [RW-1:0]  ex_rd;
    logic           ex_branch_taken;
    logic           ex_muldiv_start;
    logic           muldiv_done;
    logic           pc_write;
    logic           pc_src;
    logic           ifid_write;
    logic           ifid_flush;
    logic           idex_write;
    logic           idex_flush;
    logic           exmem_flush;
    logic           halted;
    logic           muldiv_timeout;
    logic [SCW-1:0] stall_count;

    exp_t           exp_q[$];
    int             n_pass;
    int             n_total;
    logic [SCW-1:0] exp_sc;
    logic           exp_to;
    logic           sc_known;

    hazard_control_unit #(
        .REG_ADDR_W     (RW),
        .MULDIV_TIMEOUT (32),
        .STALL_CNT_W    (SCW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_halt         (id_halt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .muldiv_done     (muldiv_done),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .halted          (halted),
        .muldiv_timeout  (muldiv_timeout),
        .stall_count     (stall_count)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, got no end, required end");
        $fatal(1);
    end

    // Monitor: pop one expectation per falling edge and compare.
    initial begin
        exp_t e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pc_write, pc_src, ifid_write, ifid_flush, idex_write,
                       idex_flush, exmem_flush, halted, muldiv_timeout};
                n_total++;
                if (got === e.ctl) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s ctl: got %b required %b", e.name, got, e.ctl);
                end
                if (e.chk_sc) begin
                    n_total++;
                    if (stall_count === e.sc) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s stall_count: got %0d required %0d",
                                 e.name, stall_count, e.sc);
                    end
                end
            end
        end
    end

    task automatic clr();
        id_rs           = 4'd0;
        id_rt           = 4'd0;
        id_uses_rt      = 1'b0;
        id_halt         = 1'b0;
        ex_mem_read     = 1'b0;
        ex_rd           = 4'd0;
        ex_branch_taken = 1'b0;
        ex_muldiv_start = 1'b0;
        muldiv_done     = 1'b0;
    endtask

    task automatic rand_inputs();
        id_rs           = 4'($urandom);
        id_rt           = 4'($urandom);
        id_uses_rt      = 1'($urandom);
        id_halt         = 1'($urandom);
        ex_mem_read     = 1'($urandom);
        ex_rd           = 4'($urandom);
        ex_branch_taken = 1'($urandom);
        ex_muldiv_start = 1'($urandom);
        muldiv_done     = 1'($urandom);
    endtask

    // One clock cycle: queue expected outputs for the current inputs, then
    // advance the expected stall count / timeout flag past the edge.
    task automatic cyc(input string nm, input logic [8:0] pat);
        exp_t e;
        e.name   = nm;
        e.ctl    = pat | {8'b0, exp_to};
        e.chk_sc = sc_known;
        e.sc     = exp_sc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_sc   = 4'd0;
            exp_to   = 1'b0;
            sc_known = 1'b1;
        end else if (!pat[8] && (exp_sc != 4'hF)) begin
            exp_sc = exp_sc + 4'd1;
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_sc   = 4'd0;
        exp_to   = 1'b0;
        sc_known = 1'b0;
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            cyc("reset", RST);
        end
        reset = 1'b0;
        clr();
        cyc("post_reset", RUN_OK);

        // Load-use detection.
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3;
        cyc("lu_rs", LU); clr();
        cyc("lu_release", RUN_OK);
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_uses_rt = 1'b1;
        cyc("lu_rt", LU); clr();
        ex_mem_read = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_rs = 4'd2;
        cyc("lu_rt_unused", RUN_OK); clr();
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs = 4'd0;
        cyc("lu_r0", RUN_OK); clr();
        ex_rd = 4'd3; id_rs = 4'd3;
        cyc("no_load", RUN_OK); clr();

        // Branch priority.
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; ex_branch_taken = 1'b1;
        cyc("br_over_lu", BR); clr();
        id_halt = 1'b1; ex_branch_taken = 1'b1;
        cyc("br_over_halt", BR); clr();
        cyc("br_no_halt", RUN_OK);
        id_halt = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd4; id_rs = 4'd4;
        cyc("lu_over_halt", LU); clr();
        cyc("lu_halt_squashed", RUN_OK);

        // Mul/div: start beats load-use, 5 stalled cycles, release on done.
        ex_muldiv_start = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3;
        cyc("md_start", RUN_OK); clr();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) ex_branch_taken = 1'b1;
            cyc("md_wait", WT); clr();
        end
        muldiv_done = 1'b1;
        cyc("md_done", RUN_OK); clr();
        cyc("md_after", RUN_OK);

        // Done coinciding with a load-use dependency.
        ex_muldiv_start = 1'b1;
        cyc("md2_start", RUN_OK); clr();
        cyc("md2_wait", WT);
        muldiv_done = 1'b1; ex_mem_read = 1'b1; ex_rd = 4'd6; id_rt = 4'd6; id_uses_rt = 1'b1;
        cyc("md2_done_lu", LU); clr();
        cyc("md2_after", RUN_OK);

        // Timeout: 32 waiting cycles without done, then sticky flag.
        ex_muldiv_start = 1'b1;
        cyc("to_start", RUN_OK); clr();
        for (int i = 0; i < 32; i++) begin
            cyc("to_wait", WT);
        end
        exp_to = 1'b1;
        cyc("to_back_run", RUN_OK);
        ex_mem_read = 1'b1; ex_rd = 4'd2; id_rs = 4'd2;
        cyc("to_sticky_lu", LU); clr();
        cyc("to_sticky", RUN_OK);
        reset = 1'b1;
        cyc("reset2", RST);
        reset = 1'b0;
        cyc("reset2_release", RUN_OK);

        // Reset in the middle of a mul/div wait.
        ex_muldiv_start = 1'b1;
        cyc("md3_start", RUN_OK); clr();
        cyc("md3_wait", WT);
        reset = 1'b1;
        cyc("reset_mid_md", RST);
        reset = 1'b0;
        cyc("md3_reset_run", RUN_OK);

        // Halt: stays halted whatever arrives, stall count saturates.
        id_halt = 1'b1;
        cyc("halt_req", RUN_OK); clr();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) ex_branch_taken = 1'b1;
            if (i == 6) ex_muldiv_start = 1'b1;
            if (i == 7) muldiv_done = 1'b1;
            cyc("halted", HLT); clr();
        end
        reset = 1'b1;
        cyc("reset3", RST);
        reset = 1'b0;
        cyc("reset3_release", RUN_OK);

        // Every queued expectation must have been consumed by now.
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_control_unit

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Central pipeline sequencer for the 16-bit pipelined CPU.
- Drives the stall, write-enable, flush and PC-select controls for the program counter and the IF/ID, ID/EX and EX/MEM stage buffers.
- Resolves four conditions: load-use hazards, taken branches, multi-cycle mul/div occupancy of EX, and HALT.
- Also keeps a saturating stall-cycle counter and a sticky mul/div timeout error.

Parameters:
- REG_ADDR_W, 4: register-specifier width; register 0 is hard-wired zero.
- MULDIV_TIMEOUT, 32: maximum cycles spent in MULDIV_WAIT before abort.
- STALL_CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_rs  in  REG_ADDR_W  source register A of the instruction in ID
- id_rt  in  REG_ADDR_W  source register B of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_halt  in  1  ID instruction is HALT
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- ex_muldiv_start  in  1  EX began a multi-cycle mul/div (single-cycle pulse)
- muldiv_done  in  1  mul/div result valid this cycle
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = PC+2, 1 = branch target
- ifid_write  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID clear
- idex_write  out  1  ID/EX write enable
- idex_flush  out  1  ID/EX clear (inserts a bubble)
- exmem_flush  out  1  EX/MEM clear
- halted  out  1  core halted
- muldiv_timeout  out  1  sticky error
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- State register (RUN, MULDIV_WAIT, HALTED) plus a timeout counter, the muldiv_timeout flag and stall_count. All control outputs are combinational from the current state and the inputs.
- Reset (synchronous, active-high):
  - state = RUN; stall_count = 0; muldiv_timeout = 0; timeout counter = 0.
  - While reset is high, outputs are pc_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1, all write enables 0, pc_src=0, halted=0.
  - Reset applied in any state, including mid mul/div, returns to RUN on the next edge.
- Default outputs in RUN with no hazard: pc_write=1, ifid_write=1, idex_write=1, all flushes 0, pc_src=0.
- Load-use hazard (RUN only):
  - Condition: ex_mem_read and ex_rd != 0 and (ex_rd == id_rs or (id_uses_rt and ex_rd == id_rt)).
  - Response in the same cycle: pc_write=0, ifid_write=0, idex_flush=1.
  - Exactly one bubble, with no state change.
- Taken branch (RUN):
  - Response: pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1.
  - Overrides a load-use hazard and id_halt in the same cycle; the halt is squashed and the state stays RUN.
- HALT: id_halt in RUN with no branch taken and no load-use hazard moves the state to HALTED at the next edge.
- Mul/div start: ex_muldiv_start in RUN moves the state to MULDIV_WAIT at the next edge.
- Priority in RUN when several conditions are true: branch > muldiv_start > load-use > halt. ex_muldiv_start and ex_branch_taken are never asserted together; if they are, the branch wins and the start is ignored.
- MULDIV_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1.
  - The timeout counter increments each cycle.
  - muldiv_done=1 releases the stall in the same cycle (RUN outputs, with the load-use check applied) and returns to RUN.
  - If the counter reaches MULDIV_TIMEOUT-1 without done, muldiv_timeout is set (sticky until reset) and the state returns to RUN.
  - ex_branch_taken is ignored in this state.
- HALTED: pc_write=0, ifid_write=0, idex_flush=1, halted=1. Only reset exits this state.
- stall_count increments in every cycle where pc_write=0 and reset is low, including HALTED. It saturates at all-ones.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding: RUN=2'd0, MULDIV_WAIT=2'd1, HALTED=2'd2;
  - REG_ADDR_W;
  - PC increment constant 16'h0002.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator. The FSM, counters and output muxing stay in hazard_control_unit.

Test Plan:
- Reset: hold reset high for 2 cycles with random inputs -> pc_write=0, ifid_flush=idex_flush=exmem_flush=1, stall_count=0, halted=0. After release: pc_write=1, ifid_write=1.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 for exactly that cycle; stall_count=1. The same stimulus with ex_rd=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 while the load-use condition holds -> pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
- Mul/div: pulse ex_muldiv_start, then assert muldiv_done 5 cycles later -> 5 stalled cycles with exmem_flush=1; release in the done cycle; stall_count=5.
- Timeout: pulse ex_muldiv_start and never assert done -> after MULDIV_TIMEOUT=32 cycles, muldiv_timeout=1 and the state returns to RUN; the flag stays set until reset.
- Halt: id_halt=1 -> halted=1 from the next cycle and pc_write=0 indefinitely; stall_count saturates at 16'hFFFF in a shortened sim (STALL_CNT_W=4 -> 4'hF). id_halt with ex_branch_taken=1 -> not halted.
